// File: rtl/y86_mem_stage.sv
// rtl/y86_mem_stage.sv - Y86-64 memory-access stage with req/ack data-memory port
// Optional: define MEM_TIMEOUT_EN to abort an access with ADR after TIMEOUT cycles without mem_ack.
module y86_mem_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata,
   input  logic        mem_err,
   output logic [63:0] valM_o,
   output logic [63:0] valE_o,
   output logic [3:0]  icode_o,
   output logic        wb_valid,
   output logic        busy,
   output logic [2:0]  stat,
   output logic        halted
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALT} state_t;

   state_t      state, state_nxt;
   logic        take;
   logic        expire;
   logic        dec_mem;
   logic        dec_we;
   logic [63:0] dec_addr;
   logic [63:0] dec_wdata;

   always_comb begin
      dec_mem   = 1'b0;
      dec_we    = 1'b0;
      dec_addr  = valE;
      dec_wdata = valA;
      case (icode)
         4'h4, 4'hA: begin dec_mem = 1'b1; dec_we = 1'b1; end
         4'h5:       dec_mem = 1'b1;
         4'h8, 4'hB: begin dec_mem = 1'b1; dec_addr = valA; end
         4'h9:       begin dec_mem = 1'b1; dec_we = 1'b1; dec_wdata = valP; end
         default:    dec_mem = 1'b0;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt;

   // Expiry is the cycle the counter would reach TIMEOUT, so mem_req lasts TIMEOUT cycles.
   assign expire = (state == ACCESS) && (tmo_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (take)
         tmo_cnt <= '0;
      else if (state == ACCESS && !mem_ack)
         tmo_cnt <= tmo_cnt + CW'(1);
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !halted) begin
               take      = 1'b1;
               state_nxt = dec_mem ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            if (mem_ack || expire)
               state_nxt = DONE;
         end
         DONE:    state_nxt = (stat == STAT_AOK) ? IDLE : HALT;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         valM_o    <= '0;
         valE_o    <= '0;
         icode_o   <= '0;
         stat      <= STAT_AOK;
      end else if (take) begin
         mem_we    <= dec_we;
         mem_addr  <= dec_addr;
         mem_wdata <= dec_wdata;
         valM_o    <= '0;
         valE_o    <= valE;
         icode_o   <= icode;
         if (icode == 4'h0)
            stat <= STAT_HLT;
         else if (icode >= 4'hC)
            stat <= STAT_INS;
      end else if (state == ACCESS) begin
         // Ack wins over a simultaneous timeout expiry.
         if (mem_ack) begin
            if (mem_err) begin
               valM_o <= '0;
               stat   <= STAT_ADR;
            end else if (!mem_we) begin
               valM_o <= mem_rdata;
            end
         end else if (expire) begin
            valM_o <= '0;
            stat   <= STAT_ADR;
         end
      end
   end

   assign mem_req  = (state == ACCESS);
   assign wb_valid = (state == DONE);
   assign busy     = (state == ACCESS) || (state == DONE);
   assign halted   = (stat != STAT_AOK);

endmodule

// File: doc/y86_mem_stage.md
Name: y86_mem_stage

Overview:
- Y86-64 memory-access stage; produces the `valE`/`valM`/`icode` triple consumed by the register-file write port in decode/writeback.
- Accepts one instruction from execute (`icode`, `valE`, `valA`, `valP`) and performs at most one 64-bit data-memory read or write over a req/ack handshake.
- Issues a single-cycle `wb_valid` to writeback and tracks the processor status code.

Parameters:
- `TIMEOUT`, 255, maximum cycles to wait for `mem_ack` before abort (used only with `MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: instruction valid from execute; sampled only in IDLE.
- `icode` in 4: instruction code.
- `valE` in 64: ALU result or stack/effective address.
- `valA` in 64: store data, or address for `ret`/`popq`.
- `valP` in 64: return address stored by `call`.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 64: memory byte address.
- `mem_wdata` out 64: write data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 64: read data, valid with `mem_ack`.
- `mem_err` in 1: bad address, valid with `mem_ack`.
- `valM_o` out 64: loaded value to writeback.
- `valE_o` out 64: registered `valE` to writeback.
- `icode_o` out 4: registered `icode` to writeback.
- `wb_valid` out 1: one-cycle pulse; `valM_o`/`valE_o`/`icode_o` valid.
- `busy` out 1: high in ACCESS and DONE.
- `stat` out 3: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `halted` out 1: high when `stat` != AOK.

Behaviour:
- Reset: all outputs 0 except `stat` = 1 (AOK). FSM goes to IDLE and the timeout counter clears. Reset mid-access drops `mem_req` immediately (asynchronous).
- FSM states: IDLE, ACCESS, DONE, HALT.
- IDLE:
  - `start` = 1 and `halted` = 0 registers `icode`, `valE`, `valA`, `valP`.
  - Memory-type icode: go to ACCESS with `mem_req` = 1 from the next cycle.
  - Any other icode: go to DONE.
  - `start` is ignored in every other state; no queueing.
- Memory decode:
  - 4 `rmmovq`: write, addr `valE`, data `valA`.
  - 5 `mrmovq`: read, addr `valE`.
  - 8 `ret`: read, addr `valA`.
  - 9 `call`: write, addr `valE`, data `valP`.
  - A `pushq`: write, addr `valE`, data `valA`.
  - B `popq`: read, addr `valA`.
  - 1, 2, 3, 6, 7: no access, `valM_o` = 0.
  - 0 `halt`: no access, `stat` <- HLT.
  - C..F: no access, `stat` <- INS.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until the cycle `mem_ack` = 1.
  - On that edge: `mem_req` <- 0; on a read, `valM_o` <- `mem_rdata`.
  - If `mem_err` = 1 on that edge: `valM_o` <- 0 and `stat` <- ADR.
  - Then go to DONE.
- `mem_ack` outside ACCESS is ignored.
- DONE:
  - `wb_valid` = 1 for exactly one cycle.
  - Next state is IDLE if `stat` = AOK, otherwise HALT.
- Latency:
  - Non-memory: `start` at T gives `wb_valid` at T+1.
  - Memory: `start` at T gives `mem_req` from T+1. `mem_ack` at cycle K (K >= T+1) gives `wb_valid` at K+1. Zero-wait ack gives `wb_valid` at T+2.
- HALT: sticky until reset. `halted` = 1, `busy` = 0, `mem_req` = 0; all starts ignored.
- `wb_valid` is also raised for halt/INS/ADR instructions so writeback can retire status. Writeback must qualify register writes with AOK.
- Width: all datapath 64-bit, no arithmetic. `mem_addr` is passed unaligned, with no checking.

Optional Feature:
- Macro `MEM_TIMEOUT_EN`.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without `mem_ack`.
  - When it reaches `TIMEOUT`: `mem_req` <- 0, `stat` <- ADR, `valM_o` <- 0, go to DONE.
  - `mem_ack` in the same cycle as expiry takes priority (normal completion).
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Reset, then `start` `icode`=6 `valE`=0x5 -> `wb_valid` one cycle later, `valE_o`=0x5, `valM_o`=0, `stat`=1, `mem_req` never asserted.
- `start` `icode`=5 `valE`=0x100; `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=0xDEADBEEF -> `mem_req` held stable with `mem_addr`=0x100 and `mem_we`=0; `valM_o`=0xDEADBEEF; `wb_valid` the cycle after ack.
- `start` `icode`=9 `valE`=0x1F8 `valP`=0x42, immediate ack -> `mem_we`=1, `mem_addr`=0x1F8, `mem_wdata`=0x42, `wb_valid` at T+2; a second `start` during ACCESS is ignored.
- `start` `icode`=B `valA`=0x200, ack with `mem_err`=1 -> `stat`=3, `valM_o`=0, one `wb_valid`, then `halted`=1 and further starts ignored until reset.
- `start` `icode`=0 -> `stat`=2, `halted`=1 after DONE; `icode`=E after reset -> `stat`=4.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=4: `icode`=4 and no ack -> `mem_req` drops after 4 cycles, `stat`=3; `rst_n` pulsed low mid-ACCESS -> `mem_req`=0 immediately and `stat`=1.
